demux_8_stream: RTL
===================

// Module: demux_8_stream
// PURPOSE
//   Registered 1-to-2 stream demultiplexer: the splitting counterpart of the 8-bit
//   2:1 mux. Routes each beat of one valid/ready input stream to output A or B.
//   Routing is either per-beat select or automatic alternation (A,B,A,B,...).
//   Each output has a one-entry register slice. Used to fan adder operand streams
//   out to two datapath lanes.
// PARAMETERS
//   WIDTH  8  data width of input and both outputs
//   CNT_W  8  width of per-channel accepted-beat counters
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   in_data     in   WIDTH  input beat
//   in_sel      in   1      0 = route to A, 1 = route to B (ignored when alt_mode=1)
//   in_valid    in   1      input beat present
//   in_ready    out  1      block accepts beat this cycle
//   alt_mode    in   1      1 = alternate A/B, ignore in_sel
//   out_a_data  out  WIDTH  channel A data
//   out_a_valid out  1      channel A beat held
//   out_a_ready in   1      channel A consumer ready
//   out_b_data  out  WIDTH  channel B data
//   out_b_valid out  1      channel B beat held
//   out_b_ready in   1      channel B consumer ready
//   cnt_a       out  CNT_W  beats accepted for A, wraps to 0
//   cnt_b       out  CNT_W  beats accepted for B, wraps to 0
// BEHAVIOUR
//   - Reset (async, rst_n=0): out_*_valid=0, out_*_data=0, cnt_a=cnt_b=0, alt ptr=A.
//     in_ready is 0 while rst_n=0.
//   - tgt = alt_mode ? ptr : in_sel.
//   - Slot X is free when !out_X_valid, or when out_X_valid & out_X_ready.
//     Same-cycle drain+refill is allowed; there is no bubble.
//   - in_ready = slot(tgt) free. It is combinational from in_sel, alt_mode, ptr,
//     out_*_valid and out_*_ready. It does not depend on in_valid.
//   - Accept = in_valid & in_ready. On accept:
//     out_tgt_data <= in_data, out_tgt_valid <= 1, cnt_tgt <= cnt_tgt+1 (mod 2^CNT_W).
//     If alt_mode=1, ptr toggles.
//   - Latency: a beat accepted in cycle N is visible on out_X in cycle N+1.
//   - Drain without refill: out_X_valid <= 0. out_X_data holds its last value.
//   - While out_X_valid=1 and out_X_ready=0, out_X_data and out_X_valid are stable.
//   - A stalled channel blocks only beats targeting it. The other channel drains and
//     fills independently. Ordering within each channel is preserved.
//   - ptr changes only on an accept. Changing alt_mode mid-stream keeps the ptr value.
//     Re-entering alt mode resumes from the held ptr.
//   - Counter wrap: 2^CNT_W-1 -> 0 silently. No overflow flag.
//   - Reset mid-operation discards held beats immediately (async). Counters clear
//     and ptr returns to A.
// TESTING
//   1. Reset with in_valid=1, in_data=8'h5A -> in_ready=0, outs invalid, cnts 0.
//      Release rst_n -> in_ready=1.
//   2. alt_mode=0, sel=0, data 8'h11, both ready=1 -> out_a=8'h11 valid next cycle.
//      cnt_a=1, B untouched.
//   3. alt_mode=1, beats 01,02,03,04 back-to-back, both ready=1 -> A gets 01,03;
//      B gets 02,04; in_ready=1 every cycle.
//   4. out_b_ready=0, sel=1 twice (8'hAA, 8'hBB) -> B holds AA, in_ready=0 on BB.
//      sel=0 beat 8'hCC still reaches A. Raise out_b_ready -> BB follows AA.
//   5. Hold out_a_valid=1 with out_a_ready=1 and stream sel=0 every cycle
//      -> one beat per cycle, no bubble.
//   6. Send 256 beats to A -> cnt_a wraps 8'hFF->8'h00. Assert rst_n=0 mid-stream
//      -> all outs invalid in the same cycle.

Source files
------------

// File: rtl/demux_8_stream.sv
// Registered 1-to-2 stream demultiplexer. Each beat goes to lane A or B, chosen per beat
// or by alternation. Each lane is a one-entry slice with its own accepted-beat counter.
module demux_8_stream_slot #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt,
  output logic             free
);
  // A held beat that is being drained this cycle frees the slot for a same-cycle refill.
  assign free = !valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      cnt   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
      cnt   <= cnt + 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

module demux_8_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             alt_mode,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);
  localparam int NUM_LANES = 2;

  logic                            ptr;
  logic                            tgt;
  logic                            accept;
  logic [NUM_LANES-1:0]            lane_free;
  logic [NUM_LANES-1:0]            lane_valid;
  logic [NUM_LANES-1:0]            lane_ready;
  logic [NUM_LANES-1:0]            lane_load;
  logic [NUM_LANES-1:0][WIDTH-1:0] lane_data;
  logic [NUM_LANES-1:0][CNT_W-1:0] lane_cnt;

  assign tgt        = alt_mode ? ptr : in_sel;
  // Gated by rst_n so nothing is offered as accepted while reset is asserted.
  assign in_ready   = rst_n && lane_free[tgt];
  assign accept     = in_valid && in_ready;
  assign lane_ready = {out_b_ready, out_a_ready};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_load[g] = accept && (tgt == 1'(g));

    demux_8_stream_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lane_load[g]),
      .din   (in_data),
      .ready (lane_ready[g]),
      .valid (lane_valid[g]),
      .data  (lane_data[g]),
      .cnt   (lane_cnt[g]),
      .free  (lane_free[g])
    );
  end

  // The pointer advances only on accepted beats in alt mode, so leaving and
  // re-entering alt mode resumes where it stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    ptr <= 1'b0;
    else if (accept && alt_mode)   ptr <= ~ptr;
  end

  assign out_a_data  = lane_data[0];
  assign out_a_valid = lane_valid[0];
  assign out_b_data  = lane_data[1];
  assign out_b_valid = lane_valid[1];
  assign cnt_a       = lane_cnt[0];
  assign cnt_b       = lane_cnt[1];
endmodule
